// File: rtl/uart_sd_sector_packer.sv
// uart_sd_sector_packer: packs UART bytes into a ring of sector buffers and streams full or flushed sectors to the SD writer
module uart_sd_sector_packer #(
    parameter int unsigned SECTOR_BYTES   = 512,
    parameter int unsigned NUM_BUFS       = 2,
    parameter logic [31:0] START_ADDR     = 32'd2000,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_done,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        flush,
    input  logic        wr_busy,
    input  logic        wr_data_req,
    output logic        wr_req,
    output logic [31:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        overflow,
    output logic [31:0] sector_cnt
);
    localparam int unsigned OW = $clog2(SECTOR_BYTES);
    localparam int unsigned PW = $clog2(NUM_BUFS);
    localparam logic [OW:0] FULL = (OW+1)'(SECTOR_BYTES);
    localparam logic [1:0] B_EMPTY = 2'd0, B_FILLING = 2'd1, B_READY = 2'd2;
    localparam logic [1:0] W_IDLE = 2'd0, W_WAIT = 2'd1, W_DATA = 2'd2, W_DONE = 2'd3;
    logic [7:0]    mem [NUM_BUFS*SECTOR_BYTES];
    logic [1:0]    buf_state [NUM_BUFS];
    logic [OW:0]   buf_len [NUM_BUFS];
    logic [PW-1:0] fill_ptr, drain_ptr;
    logic [OW:0]   fill_cnt, rd_cnt, cnt_next;
    logic [31:0]   idle_cnt;
    logic [1:0]    w_state;
    logic          store, close, idle_hit;
    always_comb begin
        store    = rx_valid && buf_state[fill_ptr] != B_READY;
        cnt_next = fill_cnt + (OW+1)'(store);
        idle_hit = TIMEOUT_CYCLES != 0 && fill_cnt != 0 && !rx_valid && idle_cnt == TIMEOUT_CYCLES - 1;
        close    = cnt_next == FULL || (cnt_next != 0 && (flush || idle_hit));
    end
    always_ff @(posedge sys_clk) begin
        if (store)
            mem[{fill_ptr, fill_cnt[OW-1:0]}] <= rx_data;
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fill_ptr <= '0;
            fill_cnt <= '0;
            idle_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (rx_valid && !store)
                overflow <= 1'b1;
            idle_cnt <= (rx_valid || close || fill_cnt == 0) ? '0 : idle_cnt + 32'd1;
            fill_cnt <= close ? '0 : cnt_next;
            if (close)
                fill_ptr <= fill_ptr + 1'b1;
        end
    end
    // Fill and drain never touch the same buffer: drain only owns READY buffers, fill never writes one.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
                buf_state[i] <= B_EMPTY;
                buf_len[i]   <= '0;
            end
            w_state    <= W_IDLE;
            drain_ptr  <= '0;
            rd_cnt     <= '0;
            wr_req     <= 1'b0;
            wr_addr    <= START_ADDR;
            wr_data    <= 8'h00;
            sector_cnt <= '0;
        end else begin
            wr_req <= 1'b0;
            if (w_state == W_DONE)
                buf_state[drain_ptr] <= B_EMPTY;
            if (store)
                buf_state[fill_ptr] <= B_FILLING;
            if (close) begin
                buf_state[fill_ptr] <= B_READY;
                buf_len[fill_ptr]   <= cnt_next;
            end
            case (w_state)
                W_IDLE: if (buf_state[drain_ptr] == B_READY && init_done && !wr_busy) begin
                    wr_req  <= 1'b1;
                    w_state <= W_WAIT;
                end
                W_WAIT: if (wr_busy) begin
                    rd_cnt  <= '0;
                    w_state <= W_DATA;
                end
                W_DATA: begin
                    if (wr_data_req) begin
                        wr_data <= rd_cnt < buf_len[drain_ptr] ? mem[{drain_ptr, rd_cnt[OW-1:0]}] : PAD_BYTE;
                        if (rd_cnt != FULL)
                            rd_cnt <= rd_cnt + 1'b1;
                    end
                    if (!wr_busy)
                        w_state <= W_DONE;
                end
                default: begin
                    drain_ptr  <= drain_ptr + 1'b1;
                    wr_addr    <= wr_addr + 32'd1;
                    sector_cnt <= sector_cnt + 32'd1;
                    w_state    <= W_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_sd_sector_packer.sv
// tb_uart_sd_sector_packer: directed bench with a behavioural SD writer capturing each sector
module tb_uart_sd_sector_packer;
    logic        clk, rst_n, init_done, rx_valid, flush, wr_data_req, busy_w, hold_busy;
    logic [7:0]  rx_data, wr_data;
    logic        wr_busy, wr_req, overflow;
    logic [31:0] wr_addr, sector_cnt;
    int          errors, checks, req_n, cap_n;
    logic [31:0] cap_addr [8];
    logic [7:0]  cap [8*512];
    logic [7:0]  exp_b [512];

    assign wr_busy = busy_w | hold_busy;

    uart_sd_sector_packer #(.TIMEOUT_CYCLES(100)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .init_done(init_done), .rx_data(rx_data),
        .rx_valid(rx_valid), .flush(flush), .wr_busy(wr_busy), .wr_data_req(wr_data_req),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .overflow(overflow),
        .sector_cnt(sector_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SD writer model: busy after wr_req, 512 byte requests two cycles apart, then release
    initial begin
        busy_w = 1'b0; wr_data_req = 1'b0; req_n = 0; cap_n = 0;
        forever begin
            @(negedge clk);
            if (wr_req && rst_n) begin
                req_n++;
                cap_addr[cap_n] = wr_addr;
                busy_w = 1'b1;
                for (int i = 0; i < 512 && rst_n; i++) begin
                    @(negedge clk);
                    wr_data_req = 1'b1;
                    @(negedge clk);
                    wr_data_req = 1'b0;
                    cap[cap_n*512+i] = wr_data;
                end
                @(negedge clk);
                busy_w = 1'b0;
                if (rst_n) cap_n++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_cap(input string tag, input int n);
        int t = 0;
        while (cap_n < n && t < 20000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk(tag, cap_n, n);
    endtask

    task automatic chk_sector(input string tag, input int idx);
        int bad = 0;
        for (int i = 0; i < 512; i++)
            if (cap[idx*512+i] !== exp_b[i]) bad++;
        chk(tag, bad, 0);
    endtask

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0; init_done = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; flush = 1'b0; hold_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_wr_addr", wr_addr, 2000);
        chk("rst_sector_cnt", sector_cnt, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_wr_data", wr_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        // full sector 00..FF twice
        for (int k = 0; k < 512; k++) send(8'(k));
        wait_cap("t1_done", 1);
        for (int k = 0; k < 512; k++) exp_b[k] = 8'(k);
        chk_sector("t1_data", 0);
        chk("t1_addr", cap_addr[0], 2000);
        chk("t1_wr_addr", wr_addr, 2001);
        chk("t1_sector_cnt", sector_cnt, 1);
        chk("t1_req_n", req_n, 1);
        // partial sector closed by idle timeout
        send(8'hAA); send(8'hBB); send(8'hCC);
        repeat (90) @(negedge clk);
        chk("t2_no_early_req", req_n, 1);
        wait_cap("t2_done", 2);
        for (int k = 0; k < 512; k++) exp_b[k] = 8'h00;
        exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC;
        chk_sector("t2_data", 1);
        chk("t2_addr", cap_addr[1], 2001);
        chk("t2_sector_cnt", sector_cnt, 2);
        // writer stalled, ring overflows
        hold_busy = 1'b1;
        for (int k = 0; k < 1536; k++) send(8'(k) ^ 8'h5A);
        repeat (10) @(negedge clk);
        chk("t3_overflow", overflow, 1);
        chk("t3_stalled", req_n, 2);
        hold_busy = 1'b0;
        wait_cap("t3_done", 4);
        repeat (200) @(negedge clk);
        chk("t3_no_third", req_n, 4);
        for (int k = 0; k < 512; k++) exp_b[k] = 8'(k) ^ 8'h5A;
        chk_sector("t3_data0", 2);
        chk_sector("t3_data1", 3);
        chk("t3_addr0", cap_addr[2], 2002);
        chk("t3_addr1", cap_addr[3], 2003);
        chk("t3_overflow_sticky", overflow, 1);
        chk("t3_sector_cnt", sector_cnt, 4);
        // card not initialised
        init_done = 1'b0;
        for (int k = 0; k < 512; k++) send(8'(k * 3));
        repeat (20) @(negedge clk);
        chk("t4_no_req", req_n, 4);
        chk("t4_wr_req_low", wr_req, 0);
        init_done = 1'b1;
        @(negedge clk);
        chk("t4_wr_req_after_init", wr_req, 1);
        wait_cap("t4_done", 5);
        for (int k = 0; k < 512; k++) exp_b[k] = 8'(k * 3);
        chk_sector("t4_data", 4);
        chk("t4_addr", cap_addr[4], 2004);
        // empty flush ignored, then byte+flush together
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (20) @(negedge clk);
        chk("t5_empty_flush", req_n, 5);
        rx_data = 8'h3C; rx_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; flush = 1'b0;
        wait_cap("t5_done", 6);
        for (int k = 0; k < 512; k++) exp_b[k] = 8'h00;
        exp_b[0] = 8'h3C;
        chk_sector("t5_data", 5);
        chk("t5_addr", cap_addr[5], 2005);
        chk("t5_sector_cnt", sector_cnt, 6);
        // reset in the middle of a transfer
        for (int k = 0; k < 512; k++) send(8'(k));
        for (int t = 0; t < 100 && req_n < 7; t++) @(negedge clk);
        repeat (50) @(negedge clk);
        chk("t6_in_transfer", busy_w, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_wr_req", wr_req, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_sector_cnt", sector_cnt, 0);
        chk("t6_wr_addr", wr_addr, 2000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("t6_buffers_empty", req_n, 7);
        chk("t6_no_commit", cap_n, 6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
